// File: rtl/vector_pkg.sv
// Shared fixed-point types and constants for the ray-tracer datapath.
// Also holds the sequential divider's FSM state type.
package vector_pkg;

  typedef logic [31:0]      fixed_real;
  typedef logic [2:0][31:0] vector;
  typedef logic [2:0][7:0]  color;

  localparam int unsigned FRAC    = 16;
  localparam fixed_real   FIX_ONE = 32'h0001_0000;
  localparam fixed_real   FIX_MAX = 32'h7FFF_FFFF;
  localparam fixed_real   FIX_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the remainder and
// subtract the divisor when it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;

  assign w_trial = {i_rem, i_bit};
  // Only the low bits matter: when the subtract is taken the result is below i_div.
  assign w_diff  = w_trial[WIDTH-1:0] - i_div;
  assign o_qbit  = (w_trial >= {1'b0, i_div});
  assign o_rem   = o_qbit ? w_diff : w_trial[WIDTH-1:0];

endmodule

// File: rtl/seq_div_real.sv
// Signed Q16.16 divider, restoring algorithm, one quotient bit per clock,
// valid/ready on both sides with a single operation in flight.
module seq_div_real
  import vector_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = vector_pkg::FRAC
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             dz,
  output logic             ovf
);

  localparam int unsigned    QBITS    = WIDTH + FRAC;
  localparam int unsigned    CW       = $clog2(QBITS);
  localparam logic [CW-1:0]  LastStep = CW'(QBITS - 1);
  localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  div_state_e       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_dz;
  logic             r_ovf;
  logic             r_sign;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_bmag;
  logic [WIDTH-1:0] r_rem;
  logic [QBITS-1:0] r_dvd;
  logic [QBITS-1:0] r_quo;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;
  logic             w_ovf_fix;
  logic [WIDTH-1:0] w_c_fix;

  // Unsigned magnitudes; the most negative value maps to exactly 2^(WIDTH-1).
  assign w_amag   = a[WIDTH-1] ? -a : a;
  assign w_bmag   = b[WIDTH-1] ? -b : b;
  assign w_b_zero = (b == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[QBITS-1]),
    .i_div  (r_bmag),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  // A negative result may reach one step further than a positive one.
  assign w_ovf_fix = r_sign ? (r_quo > {{FRAC{1'b0}}, SatNeg})
                            : (r_quo > {{FRAC{1'b0}}, SatPos});
  assign w_c_fix   = w_ovf_fix ? (r_sign ? SatNeg : SatPos)
                               : (r_sign ? -r_quo[WIDTH-1:0] : r_quo[WIDTH-1:0]);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_sign      <= 1'b0;
      r_c         <= '0;
      r_bmag      <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid && r_in_ready) begin
            r_sign     <= a[WIDTH-1] ^ b[WIDTH-1];
            r_bmag     <= w_bmag;
            r_dvd      <= {w_amag, {FRAC{1'b0}}};
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (w_b_zero) begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
              r_dz        <= 1'b1;
              r_ovf       <= 1'b0;
              r_c         <= a[WIDTH-1] ? SatNeg : SatPos;
            end else begin
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[QBITS-2:0], 1'b0};
          r_quo <= {r_quo[QBITS-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LastStep) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_c         <= w_c_fix;
          r_ovf       <= w_ovf_fix;
          r_dz        <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign dz        = r_dz;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_div_real.sv
// Scoreboard bench for seq_div_real: a 64-bit reference divide predicts each
// result, checked together with latency, backpressure and mid-run reset.
module tb_seq_div_real;

  logic        Clk       = 1'b0;
  logic        Reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] c;
  logic        dz;
  logic        ovf;

  typedef struct packed {
    logic [31:0] c;
    logic        dz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  logic [31:0] vec_a [0:9] = '{32'h0003_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000,
                               32'h0001_0000, 32'hFFFF_0000, 32'h7FFF_0000, 32'h8000_0000,
                               32'h0000_0000, 32'h8000_0000};
  logic [31:0] vec_b [0:9] = '{32'h0002_0000, 32'h0004_0000, 32'h0003_0000, 32'h0003_0000,
                               32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 32'h0001_0000,
                               32'h0003_0000, 32'hFFFF_0000};

  always #5 Clk = ~Clk;

  seq_div_real dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .dz        (dz),
    .ovf       (ovf)
  );

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint num;
    longint den;
    longint q;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    e.c   = '0;
    if (y == 32'd0) begin
      e.dz = 1'b1;
      e.c  = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      num = longint'($signed(x)) * 65536;
      den = longint'($signed(y));
      q   = num / den;
      if (q > 64'sd2147483647) begin
        e.ovf = 1'b1;
        e.c   = 32'h7FFF_FFFF;
      end else if (q < -64'sd2147483648) begin
        e.ovf = 1'b1;
        e.c   = 32'h8000_0000;
      end else begin
        e.c = q[31:0];
      end
    end
    return e;
  endfunction

  // Drive one operand pair; returns just after the accepting edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    int guard = 0;
    @(negedge Clk);
    while (!in_ready && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    if (!in_ready) begin
      n_run++;
      n_fail++;
      $display("FAIL start_wait: in_ready=%b, required 1 within 200 cycles", in_ready);
    end
    a        = x;
    b        = y;
    in_valid = 1'b1;
    sb.push_back(model(x, y));
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output logic [31:0] oc, output logic odz,
                         output logic oovf);
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!out_valid && lat < 200);
    oc   = c;
    odz  = dz;
    oovf = ovf;
  endtask

  task automatic consume(output logic ov, output logic ir);
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
    ov = out_valid;
    ir = in_ready;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset in_ready: got %b, required 1", in_ready);
    end
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset out_valid: got %b, required 0", out_valid);
    end
    n_run++;
    if ({c, dz, ovf} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset c/dz/ovf: got %h/%b/%b, required 0/0/0", c, dz, ovf);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_divide();
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] oc;
    logic        odz;
    logic        oovf;
    logic        ov;
    logic        ir;
    int          lat;
    int          exp_lat;
    exp_t        e;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        x = vec_a[i];
        y = vec_b[i];
      end else begin
        x = $urandom;
        y = $urandom >> $urandom_range(0, 20);
      end
      exp_lat = (y == 32'd0) ? 1 : 50;
      start_op(x, y);
      collect(lat, oc, odz, oovf);
      e = sb.pop_front();
      n_run++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("FAIL div[%0d] latency a=%h b=%h: got %0d, required %0d", i, x, y, lat, exp_lat);
      end
      n_run++;
      if (oc !== e.c) begin
        n_fail++;
        $display("FAIL div[%0d] c a=%h b=%h: got %h, required %h", i, x, y, oc, e.c);
      end
      n_run++;
      if ({odz, oovf} !== {e.dz, e.ovf}) begin
        n_fail++;
        $display("FAIL div[%0d] dz/ovf a=%h b=%h: got %b/%b, required %b/%b", i, x, y, odz,
                 oovf, e.dz, e.ovf);
      end
      consume(ov, ir);
      n_run++;
      if ({ov, ir} !== 2'b01) begin
        n_fail++;
        $display("FAIL div[%0d] release out_valid/in_ready: got %b/%b, required 0/1", i, ov, ir);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] oc;
    logic        odz;
    logic        oovf;
    logic        ov;
    logic        ir;
    int          lat;
    exp_t        e;
    start_op(32'h0003_0000, 32'h0002_0000);
    collect(lat, oc, odz, oovf);
    e = sb.pop_front();
    for (int k = 0; k < 10; k++) begin
      a        = 32'h0005_0000;
      b        = 32'h0001_0000;
      in_valid = 1'b1;
      @(negedge Clk);
      n_run++;
      if ({out_valid, in_ready, c, dz, ovf} !== {1'b1, 1'b0, e.c, e.dz, e.ovf}) begin
        n_fail++;
        $display("FAIL hold[%0d] valid/ready/c/dz/ovf: got %b/%b/%h/%b/%b, required 1/0/%h/%b/%b",
                 k, out_valid, in_ready, c, dz, ovf, e.c, e.dz, e.ovf);
      end
    end
    in_valid = 1'b0;
    consume(ov, ir);
    n_run++;
    if ({ov, ir} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold release out_valid/in_ready: got %b/%b, required 0/1", ov, ir);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oc;
    logic        odz;
    logic        oovf;
    logic        ov;
    logic        ir;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      start_op(32'h0001_0000 + i, 32'h0003_0000);
      collect(lat, oc, odz, oovf);
      e = sb.pop_front();
      n_run++;
      if ({oc, odz, oovf} !== {e.c, e.dz, e.ovf} || lat !== 50) begin
        n_fail++;
        $display("FAIL b2b[%0d] c/dz/ovf/lat: got %h/%b/%b/%0d, required %h/%b/%b/50", i, oc, odz,
                 oovf, lat, e.c, e.dz, e.ovf);
      end
      consume(ov, ir);
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b scoreboard residue: got %0d entries, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] oc;
    logic        odz;
    logic        oovf;
    logic        ov;
    logic        ir;
    int          lat;
    exp_t        e;
    start_op(32'h0005_0000, 32'h0007_0000);
    void'(sb.pop_front());
    repeat (20) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    n_run++;
    if ({in_ready, out_valid, c} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL midreset in_ready/out_valid/c: got %b/%b/%h, required 1/0/0", in_ready,
               out_valid, c);
    end
    start_op(32'h0003_0000, 32'h0002_0000);
    collect(lat, oc, odz, oovf);
    e = sb.pop_front();
    n_run++;
    if (lat !== 50) begin
      n_fail++;
      $display("FAIL midreset latency: got %0d, required 50", lat);
    end
    n_run++;
    if ({oc, odz, oovf} !== {e.c, e.dz, e.ovf}) begin
      n_fail++;
      $display("FAIL midreset c/dz/ovf: got %h/%b/%b, required %h/%b/%b", oc, odz, oovf, e.c,
               e.dz, e.ovf);
    end
    consume(ov, ir);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
